// File: rtl/combi_mac_pipe.sv
// combi_mac_pipe: two-stage pipelined a*b+c / accumulate MAC with valid
// tagging, optional saturation and an overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   in_valid   operands valid this cycle
//   mode       0: result = a*b + c, 1: result += a*b
//   clr        clear accumulator, carried down the pipeline with the operands
//   a, b       unsigned multiplicand / multiplier
//   c          unsigned addend, ignored in mode 1
//   out_valid  result was updated on the last edge
//   ovf        the sum overflowed RES_W bits; gated low unless out_valid is 1
//   result     registered result, which is also the accumulator
module combi_mac_pipe #(
    parameter int A_W   = 4,
    parameter int B_W   = 4,
    parameter int C_W   = 8,
    parameter int RES_W = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             clr,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    output logic             out_valid,
    output logic             ovf,
    output logic [RES_W-1:0] result
);

    localparam int P_W = A_W + B_W;

    typedef struct packed {
        logic           valid;
        logic           mode;
        logic           clr;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
    } s1_t;

    s1_t          s1;
    logic         ovf_q;

    logic [P_W-1:0]   prod;
    logic [RES_W:0]   prod_x;
    logic [RES_W:0]   c_x;
    logic [RES_W:0]   acc_x;
    logic [RES_W:0]   sum;
    logic [RES_W-1:0] res_next;

    // Both operands are widened to the full product width before the
    // multiply so the product cannot be truncated.
    assign prod   = {{B_W{1'b0}}, s1.a} * {{A_W{1'b0}}, s1.b};
    assign prod_x = {{(RES_W + 1 - P_W){1'b0}}, prod};
    assign c_x    = {{(RES_W + 1 - C_W){1'b0}}, s1.c};

    // Accumulation feeds back the registered result, so back-to-back
    // mode-1 samples chain without a forwarding path.
    assign acc_x  = s1.clr ? '0 : {1'b0, result};

    always_comb begin
        sum = '0;
        unique case (1'b1)
            !s1.mode: sum = prod_x + c_x;
            s1.mode:  sum = acc_x + prod_x;
            default:  sum = '0;
        endcase
    end

    assign res_next = (SAT && sum[RES_W]) ? '1 : sum[RES_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1        <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1.valid  <= in_valid;
            s1.mode   <= mode;
            s1.clr    <= clr;
            s1.a      <= a;
            s1.b      <= b;
            s1.c      <= c;
            out_valid <= s1.valid;
            if (s1.valid) begin
                result <= res_next;
                ovf_q  <= sum[RES_W];
            end else if (s1.clr) begin
                // A bubble carrying clr still resets the accumulator.
                result <= '0;
                ovf_q  <= 1'b0;
            end
        end
    end

    // The flag register holds across bubbles; the port only shows it
    // alongside a fresh result.
    assign ovf = ovf_q & out_valid;

endmodule

// File: tb/tb_combi_mac_pipe.sv
// tb_combi_mac_pipe: directed-vector bench for combi_mac_pipe, driving a
// wrapping (SAT=0) and a saturating (SAT=1) instance with the same inputs.
module tb_combi_mac_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       mode;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic       ov0, ov1;
    logic       of0, of1;
    logic [7:0] r0, r1;

    int ntests;
    int nfail;

    combi_mac_pipe #(.SAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .clr(clr), .a(a), .b(b), .c(c),
        .out_valid(ov0), .ovf(of0), .result(r0)
    );

    combi_mac_pipe #(.SAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .clr(clr), .a(a), .b(b), .c(c),
        .out_valid(ov1), .ovf(of1), .result(r1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic cl,
                         input logic [3:0] ta, input logic [3:0] tb,
                         input logic [7:0] tc);
        in_valid = v;
        mode     = m;
        clr      = cl;
        a        = ta;
        b        = tb;
        c        = tc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0);
    endtask

    // Checks both instances against their own expected triples.
    task automatic expect2(input string tag, input logic v,
                           input logic [7:0] e0, input logic f0,
                           input logic [7:0] e1, input logic f1);
        check({tag, ".v0"}, {31'd0, ov0}, {31'd0, v});
        check({tag, ".r0"}, {24'd0, r0}, {24'd0, e0});
        check({tag, ".o0"}, {31'd0, of0}, {31'd0, f0});
        check({tag, ".v1"}, {31'd0, ov1}, {31'd0, v});
        check({tag, ".r1"}, {24'd0, r1}, {24'd0, e1});
        check({tag, ".o1"}, {31'd0, of1}, {31'd0, f1});
    endtask

    logic [3:0] va [5];
    logic [3:0] vb [5];
    logic [7:0] vc [5];
    logic [7:0] ve [5];

    initial begin
        ntests = 0;
        nfail  = 0;
        rst    = 1'b0;
        idle();

        // 1: reset held two cycles while inputs toggle
        drive(1'b1, 1'b0, 1'b0, 4'd9, 4'd9, 8'd200);
        step();
        drive(1'b1, 1'b1, 1'b1, 4'd15, 4'd3, 8'd17);
        step();
        expect2("rst", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        idle();
        step();
        expect2("rst_rel", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

        // 2: mode-0 stream, one result per cycle
        va = '{4'd3, 4'd2, 4'd4, 4'd5, 4'd1};
        vb = '{4'd3, 4'd2, 4'd10, 4'd5, 4'd1};
        vc = '{8'd7, 8'd2, 8'd2, 8'd19, 8'd11};
        ve = '{8'd16, 8'd6, 8'd42, 8'd44, 8'd12};
        for (int i = 0; i <= 5; i++) begin
            if (i < 5)
                drive(1'b1, 1'b0, 1'b0, va[i], vb[i], vc[i]);
            else
                idle();
            step();
            if (i >= 1)
                expect2($sformatf("m0_%0d", i - 1), 1'b1,
                        ve[i-1], 1'b0, ve[i-1], 1'b0);
        end
        step();
        expect2("m0_idle", 1'b0, 8'd12, 1'b0, 8'd12, 1'b0);

        // 3: accumulate with clr, then a bubble
        drive(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 8'd99);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd2, 4'd2, 8'd99);
        step();
        expect2("acc_9", 1'b1, 8'd9, 1'b0, 8'd9, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd10, 8'd0);
        step();
        expect2("acc_13", 1'b1, 8'd13, 1'b0, 8'd13, 1'b0);
        idle();
        step();
        expect2("acc_53", 1'b1, 8'd53, 1'b0, 8'd53, 1'b0);
        step();
        expect2("acc_hold", 1'b0, 8'd53, 1'b0, 8'd53, 1'b0);

        // clr on a bubble clears the accumulator without out_valid
        drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 8'd0);
        step();
        idle();
        step();
        expect2("bub_clr", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

        // 4: accumulator overflow, wrap vs clamp
        drive(1'b1, 1'b1, 1'b1, 4'd15, 4'd15, 8'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd5, 4'd5, 8'd0);
        step();
        expect2("acc_225", 1'b1, 8'd225, 1'b0, 8'd225, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 8'd0);
        step();
        expect2("acc_250", 1'b1, 8'd250, 1'b0, 8'd250, 1'b0);
        idle();
        step();
        expect2("acc_ovf", 1'b1, 8'd3, 1'b1, 8'd255, 1'b1);
        step();
        expect2("ovf_gate", 1'b0, 8'd3, 1'b0, 8'd255, 1'b0);

        // 5: mode-0 overflow; clr ignored in mode 0
        drive(1'b1, 1'b0, 1'b1, 4'd15, 4'd15, 8'd255);
        step();
        idle();
        step();
        expect2("m0_ovf", 1'b1, 8'd224, 1'b1, 8'd255, 1'b1);

        // 6: reset while a valid sample is in flight
        drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 8'd0);
        step();
        rst = 1'b0;
        idle();
        step();
        rst = 1'b1;
        step();
        expect2("flush", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 8'd0);
        step();
        idle();
        step();
        expect2("post_rst", 1'b1, 8'd9, 1'b0, 8'd9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
